// File: rtl/sound_sequencer_pkg.sv
// Shared sound definitions: oscillator mode, sound IDs, note format and the note ROM.
package sound_pkg;

    typedef enum logic {
        OFF = 1'b0,
        ON  = 1'b1
    } MODE_TYPES;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PLAY,
        ST_GAP,
        ST_DONE
    } seq_state_t;

    localparam int unsigned SND_MOVE  = 0;
    localparam int unsigned SND_EAT   = 1;
    localparam int unsigned SND_START = 2;
    localparam int unsigned SND_CRASH = 3;

    typedef struct packed {
        logic [8:0] freq;
        logic [7:0] dur;
    } note_t;

    // A dur of 0 terminates the sequence; a freq of 0 is a rest.
    function automatic note_t sound_rom(input int unsigned id, input int unsigned idx);
        note_t n;
        n = '{freq: '0, dur: '0};
        case (id)
            SND_MOVE: begin
                if (idx == 0) n = '{freq: 9'd262, dur: 8'd1};
            end
            SND_EAT: begin
                case (idx)
                    0:       n = '{freq: 9'd330, dur: 8'd2};
                    1:       n = '{freq: 9'd440, dur: 8'd2};
                    default: n = '{freq: '0, dur: '0};
                endcase
            end
            SND_START: begin
                case (idx)
                    0:       n = '{freq: 9'd262, dur: 8'd3};
                    1:       n = '{freq: 9'd330, dur: 8'd3};
                    2:       n = '{freq: 9'd392, dur: 8'd3};
                    3:       n = '{freq: 9'd494, dur: 8'd3};
                    default: n = '{freq: '0, dur: '0};
                endcase
            end
            SND_CRASH: begin
                case (idx)
                    0:       n = '{freq: 9'd196, dur: 8'd4};
                    1:       n = '{freq: 9'd0,   dur: 8'd2};
                    2:       n = '{freq: 9'd131, dur: 8'd8};
                    default: n = '{freq: '0, dur: '0};
                endcase
            end
            default: n = '{freq: '0, dur: '0};
        endcase
        return n;
    endfunction

endpackage

// File: rtl/sound_sequencer_if.sv
// Request/oscillator bundle between the game FSM (master) and the sequencer (slave).
interface sound_sequencer_if #(
    parameter int unsigned NUM_REQ = 4
);
    import sound_pkg::*;

    localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic               sound_en;
    logic [NUM_REQ-1:0] req;
    logic [8:0]         freq;
    MODE_TYPES          osc_state;
    logic               play_sound;
    logic               busy;
    logic [ID_W-1:0]    active_id;
    logic               done;

    modport master (
        output sound_en, req,
        input  freq, osc_state, play_sound, busy, active_id, done
    );

    modport slave (
        input  sound_en, req,
        output freq, osc_state, play_sound, busy, active_id, done
    );

endinterface

// File: rtl/sound_sequencer_tick_gen.sv
// Duration tick generator: wraps every TICK_DIV enabled cycles, synchronous clear.
module sound_sequencer_tick_gen #(
    parameter int unsigned TICK_DIV = 100000
) (
    input  logic clk,
    input  logic nRst,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);
    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             at_top;

    assign at_top = (cnt_q == CNT_W'(TICK_DIV - 1));
    assign tick_o = en_i && !clr_i && at_top;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = at_top ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/sound_sequencer.sv
// Priority sound-event sequencer driving the shared tone oscillator from the note ROM.
module sound_sequencer
    import sound_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned MAX_NOTES = 4,
    parameter int unsigned TICK_DIV  = 100000,
    parameter int unsigned GAP_TICKS = 1
) (
    input logic              clk,
    input logic              nRst,
    sound_sequencer_if.slave bus
);
    localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned IDX_W = $clog2(MAX_NOTES) + 1;

    seq_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] pending_q, pending_d;
    logic [NUM_REQ-1:0] req_v, cand;
    logic [ID_W-1:0]    active_id_q, active_id_d, grant_id;
    logic [IDX_W-1:0]   idx_q, idx_d, idx_next;
    logic [7:0]         rem_q, rem_d;
    logic [8:0]         freq_q, freq_d;
    MODE_TYPES          osc_q, osc_d;
    logic               play_q, play_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               grant_any, in_sound, preempt, to_done;
    logic               tick, tick_en;
    note_t              note;

    assign tick_en = (state_q == ST_PLAY) || (state_q == ST_GAP);

    sound_sequencer_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .nRst   (nRst),
        .en_i   (tick_en),
        .clr_i  (!tick_en),
        .tick_o (tick)
    );

    assign note     = sound_rom(32'(active_id_q), 32'(idx_q));
    assign idx_next = idx_q + IDX_W'(1);

    // Requests for the sound already playing are dropped before they reach pending.
    always_comb begin
        req_v    = bus.req & {NUM_REQ{bus.sound_en}};
        in_sound = (state_q == ST_LOAD) || (state_q == ST_PLAY) || (state_q == ST_GAP);
        if (in_sound) req_v[active_id_q] = 1'b0;
        cand      = pending_q | req_v;
        grant_any = |cand;
        grant_id  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (cand[i]) grant_id = ID_W'(i);
        end
        preempt = in_sound && grant_any && (grant_id > active_id_q);
    end

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q | req_v;
        active_id_d = active_id_q;
        idx_d       = idx_q;
        rem_d       = rem_q;
        freq_d      = freq_q;
        osc_d       = osc_q;
        play_d      = play_q;
        done_d      = 1'b0;
        to_done     = 1'b0;

        if (!bus.sound_en) begin
            state_d     = ST_IDLE;
            pending_d   = '0;
            active_id_d = '0;
            idx_d       = '0;
            rem_d       = '0;
            freq_d      = '0;
            osc_d       = OFF;
            play_d      = 1'b0;
        end else if ((state_q == ST_IDLE && grant_any) || preempt) begin
            state_d             = ST_LOAD;
            active_id_d         = grant_id;
            idx_d               = '0;
            pending_d[grant_id] = 1'b0;
            play_d              = 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (note.dur == '0) begin
                        to_done = 1'b1;
                    end else begin
                        state_d = ST_PLAY;
                        freq_d  = note.freq;
                        osc_d   = ON;
                        play_d  = (note.freq != '0);
                        rem_d   = note.dur;
                    end
                end
                ST_PLAY: begin
                    if (tick) begin
                        if (rem_q == 8'd1) begin
                            state_d = ST_GAP;
                            rem_d   = 8'(GAP_TICKS);
                            play_d  = 1'b0;
                        end else begin
                            rem_d = rem_q - 8'd1;
                        end
                    end
                end
                ST_GAP: begin
                    if (tick) begin
                        if (rem_q == 8'd1) begin
                            idx_d = idx_next;
                            if (idx_next == IDX_W'(MAX_NOTES)) to_done = 1'b1;
                            else                               state_d = ST_LOAD;
                        end else begin
                            rem_d = rem_q - 8'd1;
                        end
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end

        if (to_done) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            play_d  = 1'b0;
            osc_d   = OFF;
            freq_d  = '0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q     <= ST_IDLE;
            pending_q   <= '0;
            active_id_q <= '0;
            idx_q       <= '0;
            rem_q       <= '0;
            freq_q      <= '0;
            osc_q       <= OFF;
            play_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            active_id_q <= active_id_d;
            idx_q       <= idx_d;
            rem_q       <= rem_d;
            freq_q      <= freq_d;
            osc_q       <= osc_d;
            play_q      <= play_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.freq       = freq_q;
    assign bus.osc_state  = osc_q;
    assign bus.play_sound = play_q;
    assign bus.busy       = busy_q;
    assign bus.active_id  = active_id_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_sound_sequencer.sv
// Randomised + directed bench for sound_sequencer against a per-cycle output timeline model.
module tb_sound_sequencer;
    localparam int TD   = 4;
    localparam int GAPT = 1;
    localparam int MAXN = 4;
    localparam int K_IDLE = 0;
    localparam int K_SND  = 1;
    localparam int K_DONE = 2;

    typedef struct {
        int freq;
        int osc;
        bit play;
        bit busy;
        int id;
        bit done;
        int kind;
    } exp_t;

    logic clk;
    logic nRst;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    exp_t     tl[$];
    exp_t     cur;
    bit [3:0] pending;

    sound_sequencer_if #(.NUM_REQ(4)) bus ();

    sound_sequencer #(
        .NUM_REQ   (4),
        .MAX_NOTES (MAXN),
        .TICK_DIV  (TD),
        .GAP_TICKS (GAPT)
    ) dut (
        .clk  (clk),
        .nRst (nRst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    // Independent copy of the sound table: note k of sound s as (freq, duration ticks).
    task automatic tb_note(input int s, input int k, output int f, output int d);
        f = 0;
        d = 0;
        case (s)
            0: if (k == 0) begin f = 262; d = 1; end
            1: case (k) 0: begin f = 330; d = 2; end 1: begin f = 440; d = 2; end default: ; endcase
            2: case (k) 0: begin f = 262; d = 3; end 1: begin f = 330; d = 3; end
                        2: begin f = 392; d = 3; end 3: begin f = 494; d = 3; end default: ; endcase
            3: case (k) 0: begin f = 196; d = 4; end 1: begin f = 0; d = 2; end
                        2: begin f = 131; d = 8; end default: ; endcase
            default: ;
        endcase
    endtask

    // Whole future of a sound as a list of post-edge outputs; -1 means "unchanged".
    task automatic build(input int s);
        int  f, d;
        bit  fin;
        fin = 0;
        tl.delete();
        for (int k = 0; k < MAXN && !fin; k++) begin
            tb_note(s, k, f, d);
            tl.push_back('{-1, -1, 1'b0, 1'b1, s, 1'b0, K_SND});
            if (d == 0) begin
                fin = 1;
            end else begin
                repeat (d * TD)    tl.push_back('{f, 1, (f != 0), 1'b1, s, 1'b0, K_SND});
                repeat (GAPT * TD) tl.push_back('{-1, 1, 1'b0, 1'b1, s, 1'b0, K_SND});
            end
        end
        tl.push_back('{0, 0, 1'b0, 1'b1, s, 1'b1, K_DONE});
        tl.push_back('{0, 0, 1'b0, 1'b0, s, 1'b0, K_IDLE});
    endtask

    task automatic model_reset();
        tl.delete();
        pending = '0;
        cur = '{0, 0, 1'b0, 1'b0, 0, 1'b0, K_IDLE};
    endtask

    task automatic model_edge(input bit en, input bit [3:0] rq);
        bit [3:0] r, cand;
        int       top;
        exp_t     e;
        if (!en) begin
            model_reset();
            return;
        end
        r = rq;
        if (cur.kind == K_SND) r[cur.id] = 1'b0;
        cand = pending | r;
        top = -1;
        for (int i = 0; i < 4; i++) if (cand[i]) top = i;
        if (top >= 0 && (cur.kind == K_IDLE || (cur.kind == K_SND && top > cur.id))) begin
            cand[top] = 1'b0;
            build(top);
        end
        pending = cand;
        if (tl.size() > 0) begin
            e = tl.pop_front();
            if (e.freq < 0) e.freq = cur.freq;
            if (e.osc < 0)  e.osc  = cur.osc;
            cur = e;
        end
    endtask

    task automatic compare_all();
        check_eq("freq",      32'(bus.freq),       cur.freq);
        check_eq("osc_state", 32'(bus.osc_state),  cur.osc);
        check_eq("play",      32'(bus.play_sound), 32'(cur.play));
        check_eq("busy",      32'(bus.busy),       32'(cur.busy));
        check_eq("active_id", 32'(bus.active_id),  cur.id);
        check_eq("done",      32'(bus.done),       32'(cur.done));
    endtask

    task automatic step(input bit en, input bit [3:0] rq);
        bus.sound_en = en;
        bus.req      = rq;
        @(posedge clk);
        model_edge(en, rq);
        @(negedge clk);
        cyc++;
        compare_all();
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, 4'b0000);
    endtask

    initial begin
        bit       en;
        int       dis;
        bit [3:0] rq;

        nRst         = 1'b0;
        bus.sound_en = 1'b0;
        bus.req      = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        compare_all();
        nRst = 1'b1;

        // EAT then CRASH on their own
        step(1'b1, 4'b0010); idle(50);
        step(1'b1, 4'b1000); idle(100);

        // START preempted by CRASH mid note 2, MOVE queued behind CRASH
        step(1'b1, 4'b0100); idle(22);
        step(1'b1, 4'b1000); idle(3);
        step(1'b1, 4'b0001); idle(150);

        // START re-requested (dropped) and EAT held pending
        step(1'b1, 4'b0100); idle(10);
        step(1'b1, 4'b0100); idle(5);
        step(1'b1, 4'b0010); idle(120);

        // mute during EAT, requests while muted are ignored
        step(1'b1, 4'b0010); idle(4);
        step(1'b0, 4'b0000);
        step(1'b0, 4'b1111);
        step(1'b0, 4'b0010);
        idle(20);

        // asynchronous reset in the middle of START
        step(1'b1, 4'b0100); idle(8);
        #1 nRst = 1'b0;
        #1 model_reset();
        compare_all();
        @(posedge clk);
        @(negedge clk);
        nRst = 1'b1;
        compare_all();
        idle(3);

        en  = 1'b1;
        dis = 0;
        for (int n = 0; n < 3000; n++) begin
            if (dis > 0) dis--;
            else if ($urandom_range(0, 199) == 0) dis = $urandom_range(1, 4);
            en = (dis == 0);
            for (int b = 0; b < 4; b++) rq[b] = ($urandom_range(0, 39) == 0);
            step(en, rq);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
